// File: rtl/affine_pkg.sv
// Shared types and constants for the affine sub-block scheduler.
package affine_pkg;

  localparam int SB_SIZE     = 4;
  localparam int MAX_PU_SIZE = 128;
  localparam int SB_IDX_W    = 10;

  // Sub-block count per PU edge needs 0..32, the position within the edge 0..31.
  localparam int DIM_W = $clog2(MAX_PU_SIZE / SB_SIZE) + 1;
  localparam int POS_W = $clog2(MAX_PU_SIZE / SB_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    CALC,
    EXPORT,
    OUT,
    DONE,
    ERR
  } sched_state_t;

  // A PU edge is legal when non-zero, not above the maximum and a whole
  // number of sub-blocks.
  function automatic logic pu_dim_ok(input logic [7:0] sz, input int max_sz,
                                     input int sb_sh);
    logic [7:0] frac_mask;
    frac_mask = 8'((1 << sb_sh) - 1);
    return (sz != 8'd0) && (int'(sz) <= max_sz) && ((sz & frac_mask) == 8'd0);
  endfunction

endpackage

// File: rtl/affine_sb_sched_if.sv
// Scheduler-side bus: MV-table read, calculator strobes/offsets and the
// downstream valid/ready handshake.
interface affine_sb_sched_if #(
  parameter int IDX_W = 10
);
  logic                    mv_rd_en;
  logic [IDX_W-1:0]        mv_rd_idx;
  logic                    calc_en;
  logic                    calc_export;
  logic signed [7:0]       sb_dx;
  logic signed [7:0]       sb_dy;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport master (
    output mv_rd_en, mv_rd_idx, calc_en, calc_export, sb_dx, sb_dy,
           out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mv_rd_en, mv_rd_idx, calc_en, calc_export, sb_dx, sb_dy,
           out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/affine_sb_raster_cnt.sv
// Raster-order row/col walker over the sub-blocks of one PU: holds the PU
// dimensions in sub-blocks, wraps col into row, flags the final block and
// forms the MV-table index row*cols+col.
module affine_sb_raster_cnt
  import affine_pkg::*;
#(
  parameter int IDX_W = SB_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIM_W-1:0] cols_in,
  input  logic [DIM_W-1:0] rows_in,
  input  logic             advance,
  output logic [POS_W-1:0] row,
  output logic [POS_W-1:0] col,
  output logic             last,
  output logic [IDX_W-1:0] idx
);

  logic [DIM_W-1:0] cols_q;
  logic [DIM_W-1:0] rows_q;
  logic [POS_W-1:0] row_q;
  logic [POS_W-1:0] col_q;
  logic             last_col;
  logic             last_row;

  assign last_col = (DIM_W'(col_q) == cols_q - DIM_W'(1));
  assign last_row = (DIM_W'(row_q) == rows_q - DIM_W'(1));
  assign last     = last_col && last_row;

  // Unsigned multiply-add; the largest result 31*32+31 fits the index width.
  assign idx = IDX_W'(row_q) * IDX_W'(cols_q) + IDX_W'(col_q);

  assign row = row_q;
  assign col = col_q;

  // Dimension latch on load, raster advance on each accepted sub-block.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_q <= '0;
      rows_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (load) begin
      cols_q <= cols_in;
      rows_q <= rows_in;
      row_q  <= '0;
      col_q  <= '0;
    end else if (advance) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= row_q + POS_W'(1);
      end else begin
        col_q <= col_q + POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/affine_sb_sched.sv
// Affine PU sub-block scheduler: walks the PU in raster order, reads each
// sub-block MV, spaces the calculator en/export strobes and hands results
// downstream over valid/ready.
// Optional build macro AFFINE_SB_SCHED_PERF_EN adds stall_cnt/sb_cnt
// performance counters.
module affine_sb_sched
  import affine_pkg::*;
#(
  parameter int MAX_PU = MAX_PU_SIZE,
  parameter int SB     = SB_SIZE,
  parameter int IDX_W  = SB_IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          pu_w,
  input  logic [7:0]          pu_h,
  output logic                busy,
  output logic                done,
  output logic                err,
  affine_sb_sched_if.master   sb_if
`ifdef AFFINE_SB_SCHED_PERF_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [9:0]          sb_cnt
`endif
);

  localparam int SB_SH = $clog2(SB);

  sched_state_t     state_q;
  sched_state_t     state_d;

  logic             load;
  logic             advance;
  logic             size_ok;
  logic [POS_W-1:0] row;
  logic [POS_W-1:0] col;
  logic             last;
  logic [IDX_W-1:0] idx;

  logic             mv_rd_en;
  logic             calc_en;
  logic             calc_export;
  logic             out_valid;
  logic             out_last;

  assign size_ok = pu_dim_ok(pu_w, MAX_PU, SB_SH) && pu_dim_ok(pu_h, MAX_PU, SB_SH);

  affine_sb_raster_cnt #(
    .IDX_W (IDX_W)
  ) u_raster_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .cols_in (DIM_W'(pu_w >> SB_SH)),
    .rows_in (DIM_W'(pu_h >> SB_SH)),
    .advance (advance),
    .row     (row),
    .col     (col),
    .last    (last),
    .idx     (idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and Moore/handshake outputs.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    advance     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    mv_rd_en    = 1'b0;
    calc_en     = 1'b0;
    calc_export = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = size_ok ? FETCH : ERR;
        end
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      FETCH: begin
        busy     = 1'b1;
        mv_rd_en = 1'b1;
        state_d  = ISSUE;
      end
      ISSUE: begin
        busy    = 1'b1;
        calc_en = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        // Calculator resolves its row address; no strobes this cycle.
        busy    = 1'b1;
        state_d = EXPORT;
      end
      EXPORT: begin
        busy        = 1'b1;
        calc_en     = 1'b1;
        calc_export = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = last;
        if (sb_if.out_ready) begin
          advance = 1'b1;
          state_d = last ? DONE : FETCH;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sb_if.mv_rd_en    = mv_rd_en;
  assign sb_if.mv_rd_idx   = mv_rd_en ? idx : '0;
  assign sb_if.calc_en     = calc_en;
  assign sb_if.calc_export = calc_export;
  assign sb_if.out_valid   = out_valid;
  assign sb_if.out_last    = out_last;
  // Offsets come straight from the counter registers, so they hold from
  // FETCH through OUT and move only on a handshake.
  assign sb_if.sb_dx       = 8'(col) << SB_SH;
  assign sb_if.sb_dy       = 8'(row) << SB_SH;

`ifdef AFFINE_SB_SCHED_PERF_EN
  // Stall-cycle (saturating) and handshake counters, cleared per PU.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      sb_cnt    <= '0;
    end else if (state_q == IDLE && start) begin
      stall_cnt <= '0;
      sb_cnt    <= '0;
    end else begin
      if (out_valid && !sb_if.out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (advance)
        sb_cnt <= sb_cnt + 10'd1;
    end
  end
`endif

endmodule

// File: tb/tb_affine_sb_sched.sv
// Directed self-checking bench for affine_sb_sched.
module tb_affine_sb_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pu_w;
  logic [7:0] pu_h;
  logic       busy;
  logic       done;
  logic       err;
`ifdef AFFINE_SB_SCHED_PERF_EN
  logic [15:0] stall_cnt;
  logic [9:0]  sb_cnt;
`endif

  affine_sb_sched_if #(.IDX_W(10)) bus ();

  affine_sb_sched dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .pu_w  (pu_w),
    .pu_h  (pu_h),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .sb_if (bus)
`ifdef AFFINE_SB_SCHED_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .sb_cnt    (sb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-run observations.
  int   hs_dx[$];
  int   hs_dy[$];
  int   hs_cyc[$];
  logic hs_last[$];
  int   rd_idx[$];
  int   stall_dx[$];
  int   stall_strobe;
  int   first_valid;
  int   done_cnt;
  int   done_cyc;
  int   err_cnt;
  int   err_cyc;
  logic busy_seen;
  logic busy_after;
  logic rd_after;
  logic timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_last();
    int n = 0;
    foreach (hs_last[i]) if (hs_last[i]) n++;
    return n;
  endfunction

  // Pulse start for one PU and observe it cycle by cycle. stall_blk is the
  // zero-based block held with out_ready=0 for stall_len cycles (-1: none).
  task automatic run_pu(input logic [7:0] w, input logic [7:0] h,
                        input int stall_blk, input int stall_len, input int budget,
                        input logic repulse_busy, input logic repulse_done);
    int   cyc;
    int   tail;
    int   stall_left;
    logic seen_end;
    hs_dx.delete(); hs_dy.delete(); hs_cyc.delete(); hs_last.delete();
    rd_idx.delete(); stall_dx.delete();
    stall_strobe = 0; first_valid = -1; done_cnt = 0; done_cyc = -1;
    err_cnt = 0; err_cyc = -1; busy_seen = 0; busy_after = 0; rd_after = 0;
    pu_w = w; pu_h = h; bus.out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; tail = 0; seen_end = 0; stall_left = stall_len;
    while (cyc <= budget && tail < 4) begin
      if (seen_end) begin
        if (busy) busy_after = 1'b1;
        if (bus.mv_rd_en) rd_after = 1'b1;
      end else begin
        if (busy) busy_seen = 1'b1;
        if (bus.mv_rd_en) rd_idx.push_back(int'(bus.mv_rd_idx));
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
        if (repulse_done) start = 1'b1;
      end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (repulse_busy && cyc == 3) start = 1'b1;
      bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (hs_dx.size() == stall_blk && stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
          stall_dx.push_back(int'(bus.sb_dx));
          if (bus.calc_en || bus.calc_export || bus.mv_rd_en) stall_strobe++;
        end else begin
          hs_dx.push_back(int'(bus.sb_dx));
          hs_dy.push_back(int'(bus.sb_dy));
          hs_cyc.push_back(cyc);
          hs_last.push_back(bus.out_last);
        end
      end
      if (done || err) seen_end = 1'b1;
      if (seen_end) tail++;
      tick();
      start = 1'b0;
      cyc++;
    end
    bus.out_ready = 1'b1;
    timed_out = !seen_end;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pu_w = '0; pu_h = '0; bus.out_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if ({busy, done, err, bus.mv_rd_en, bus.calc_en, bus.calc_export,
         bus.out_valid, bus.out_last} !== 8'h00) begin
      $display("FAIL reset_strobes: got %b expected 00000000",
               {busy, done, err, bus.mv_rd_en, bus.calc_en, bus.calc_export,
                bus.out_valid, bus.out_last});
      n_errors++;
    end
    n_checks++;
    if (bus.sb_dx !== 8'sd0 || bus.sb_dy !== 8'sd0 || bus.mv_rd_idx !== 10'd0) begin
      $display("FAIL reset_offsets: got dx=%0d dy=%0d idx=%0d expected 0 0 0",
               bus.sb_dx, bus.sb_dy, bus.mv_rd_idx);
      n_errors++;
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_pu_8x8();
    int exp_dx[4];
    int exp_dy[4];
    exp_dx = '{0, 4, 0, 4};
    exp_dy = '{0, 0, 4, 4};
    run_pu(8'd8, 8'd8, -1, 0, 60, 1'b0, 1'b0);
    n_checks++;
    if (timed_out || hs_dx.size() != 4) begin
      $display("FAIL 8x8_count: got %0d handshakes (timeout=%0d) expected 4",
               hs_dx.size(), timed_out);
      n_errors++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (hs_dx[i] !== exp_dx[i] || hs_dy[i] !== exp_dy[i] || rd_idx[i] !== i) begin
        $display("FAIL 8x8_blk%0d: got dx=%0d dy=%0d idx=%0d expected %0d %0d %0d",
                 i, hs_dx[i], hs_dy[i], rd_idx[i], exp_dx[i], exp_dy[i], i);
        n_errors++;
      end
    end
    n_checks++;
    if (count_last() != 1 || hs_last[3] !== 1'b1) begin
      $display("FAIL 8x8_last: got %0d last flags, last on blk3=%b expected 1 and 1",
               count_last(), hs_last[3]);
      n_errors++;
    end
    n_checks++;
    if (first_valid != 5) begin
      $display("FAIL 8x8_latency: got %0d expected 5", first_valid);
      n_errors++;
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != hs_cyc[3] + 1) begin
      $display("FAIL 8x8_done: got count=%0d cyc=%0d expected 1 at %0d",
               done_cnt, done_cyc, hs_cyc[3] + 1);
      n_errors++;
    end
  endtask

  task automatic test_stall_16x8();
    run_pu(8'd16, 8'd8, 1, 3, 80, 1'b0, 1'b0);
    n_checks++;
    if (timed_out || hs_dx.size() != 8) begin
      $display("FAIL stall_count: got %0d handshakes (timeout=%0d) expected 8",
               hs_dx.size(), timed_out);
      n_errors++;
    end
    n_checks++;
    if (stall_dx.size() != 3 || stall_dx[0] !== 4 || stall_dx[1] !== 4 || stall_dx[2] !== 4) begin
      $display("FAIL stall_hold: got %0d stall cycles dx=%0d,%0d,%0d expected 3 cycles dx=4",
               stall_dx.size(), stall_dx[0], stall_dx[1], stall_dx[2]);
      n_errors++;
    end
    n_checks++;
    if (stall_strobe != 0) begin
      $display("FAIL stall_strobes: got %0d strobe cycles expected 0", stall_strobe);
      n_errors++;
    end
    n_checks++;
    if (hs_dx[1] !== 4 || hs_dx[2] !== 8 || hs_dx[4] !== 0 || hs_dy[4] !== 4) begin
      $display("FAIL stall_seq: got dx1=%0d dx2=%0d dx4=%0d dy4=%0d expected 4 8 0 4",
               hs_dx[1], hs_dx[2], hs_dx[4], hs_dy[4]);
      n_errors++;
    end
    n_checks++;
    if (rd_idx.size() != 8 || rd_idx[7] !== 7) begin
      $display("FAIL stall_idx: got %0d reads last=%0d expected 8 reads last=7",
               rd_idx.size(), rd_idx[7]);
      n_errors++;
    end
`ifdef AFFINE_SB_SCHED_PERF_EN
    n_checks++;
    if (stall_cnt !== 16'd3 || sb_cnt !== 10'd8) begin
      $display("FAIL perf_cnt: got stall=%0d sb=%0d expected 3 8", stall_cnt, sb_cnt);
      n_errors++;
    end
`endif
  endtask

  task automatic test_pu_128x128();
    run_pu(8'd128, 8'd128, -1, 0, 6000, 1'b0, 1'b0);
    n_checks++;
    if (timed_out || hs_dx.size() != 1024) begin
      $display("FAIL max_count: got %0d handshakes (timeout=%0d) expected 1024",
               hs_dx.size(), timed_out);
      n_errors++;
    end
    n_checks++;
    if (hs_dx[33] !== 4 || hs_dy[33] !== 4 || rd_idx[33] !== 33) begin
      $display("FAIL max_blk33: got dx=%0d dy=%0d idx=%0d expected 4 4 33",
               hs_dx[33], hs_dy[33], rd_idx[33]);
      n_errors++;
    end
    n_checks++;
    if (hs_dx[1023] !== 124 || hs_dy[1023] !== 124 || rd_idx[1023] !== 1023) begin
      $display("FAIL max_final: got dx=%0d dy=%0d idx=%0d expected 124 124 1023",
               hs_dx[1023], hs_dy[1023], rd_idx[1023]);
      n_errors++;
    end
    n_checks++;
    if (count_last() != 1 || hs_last[1023] !== 1'b1 || done_cnt != 1) begin
      $display("FAIL max_last: got last=%0d final=%b done=%0d expected 1 1 1",
               count_last(), hs_last[1023], done_cnt);
      n_errors++;
    end
  endtask

  task automatic test_illegal();
    logic [7:0] ws[3];
    logic [7:0] hs[3];
    ws = '{8'd6, 8'd8, 8'd132};
    hs = '{8'd8, 8'd0, 8'd8};
    for (int i = 0; i < 3; i++) begin
      run_pu(ws[i], hs[i], -1, 0, 20, 1'b0, 1'b0);
      n_checks++;
      if (err_cnt != 1 || err_cyc != 1) begin
        $display("FAIL illegal_err_%0dx%0d: got count=%0d cyc=%0d expected 1 at 1",
                 ws[i], hs[i], err_cnt, err_cyc);
        n_errors++;
      end
      n_checks++;
      if (busy_seen || rd_idx.size() != 0 || hs_dx.size() != 0 || done_cnt != 0) begin
        $display("FAIL illegal_quiet_%0dx%0d: got busy=%b reads=%0d hs=%0d done=%0d expected 0",
                 ws[i], hs[i], busy_seen, rd_idx.size(), hs_dx.size(), done_cnt);
        n_errors++;
      end
    end
  endtask

  task automatic test_reset_mid_pu();
    int k;
    int bad;
    pu_w = 8'd8; pu_h = 8'd8; bus.out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 10) begin tick(); k++; end
    n_checks++;
    if (!bus.out_valid) begin
      $display("FAIL midrst_reach_out: got out_valid=0 expected 1 within 10 cycles");
      n_errors++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if ({busy, done, err, bus.mv_rd_en, bus.calc_en, bus.calc_export,
         bus.out_valid, bus.out_last} !== 8'h00 || bus.sb_dx !== 8'sd0 ||
        bus.sb_dy !== 8'sd0) begin
      $display("FAIL midrst_outputs: got %b dx=%0d dy=%0d expected all 0",
               {busy, done, err, bus.mv_rd_en, bus.calc_en, bus.calc_export,
                bus.out_valid, bus.out_last}, bus.sb_dx, bus.sb_dy);
      n_errors++;
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy || bus.out_valid) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      $display("FAIL midrst_idle: got %0d active cycles expected 0", bad);
      n_errors++;
    end
    run_pu(8'd4, 8'd4, -1, 0, 30, 1'b0, 1'b0);
    n_checks++;
    if (timed_out || hs_dx.size() != 1 || hs_last[0] !== 1'b1 || done_cnt != 1 ||
        rd_idx[0] !== 0) begin
      $display("FAIL midrst_4x4: got hs=%0d last=%b done=%0d idx=%0d expected 1 1 1 0",
               hs_dx.size(), hs_last[0], done_cnt, rd_idx[0]);
      n_errors++;
    end
  endtask

  task automatic test_start_ignored();
    run_pu(8'd8, 8'd8, -1, 0, 60, 1'b1, 1'b1);
    n_checks++;
    if (timed_out || done_cnt != 1 || hs_dx.size() != 4 || rd_idx.size() != 4) begin
      $display("FAIL repulse_single: got done=%0d hs=%0d reads=%0d expected 1 4 4",
               done_cnt, hs_dx.size(), rd_idx.size());
      n_errors++;
    end
    n_checks++;
    if (busy_after || rd_after) begin
      $display("FAIL repulse_at_done: got busy=%b read=%b after done expected 0 0",
               busy_after, rd_after);
      n_errors++;
    end
  endtask

  initial begin
    test_reset();
    test_pu_8x8();
    test_stall_16x8();
    test_pu_128x128();
    test_illegal();
    test_reset_mid_pu();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
